// File: rtl/dm_stage.sv
// M-stage data memory: word RAM with sub-word store merge and load extract/extend.
// Optional write trace enabled by defining DM_WRITE_TRACE_EN.
module dm_stage #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_op,
  input  logic [2:0]  load_op,
  output logic [31:0] rdata,
  output logic [3:0]  byte_en
);

  localparam logic [1:0] ST_SW = 2'b01;
  localparam logic [1:0] ST_SH = 2'b10;
  localparam logic [1:0] ST_SB = 2'b11;

  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] widx;
  logic              in_range;
  logic [31:0]       word;
  logic [31:0]       lane_data;
  logic [31:0]       merged_word;
  logic [31:0]       byte_shift;
  logic [31:0]       half_shift;

  assign widx     = addr[ADDR_W+1:2];
  assign in_range = (addr[31:2] < 30'(DEPTH));
  assign word     = in_range ? mem[widx] : 32'h0;

  always_comb begin
    byte_en = 4'b0000;
    case (store_op)
      ST_SW:   byte_en = 4'b1111;
      ST_SH:   byte_en = addr[1] ? 4'b1100 : 4'b0011;
      ST_SB:   byte_en = 4'b0001 << addr[1:0];
      default: byte_en = 4'b0000;
    endcase
    if (!in_range) byte_en = 4'b0000;
  end

  // Narrow stores replicate their data so any lane can pick it up.
  always_comb begin
    lane_data = wdata;
    case (store_op)
      ST_SH:   lane_data = {2{wdata[15:0]}};
      ST_SB:   lane_data = {4{wdata[7:0]}};
      default: lane_data = wdata;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (byte_en != 4'b0000) begin
      mem[widx] <= merged_word;
    end
  end

`ifdef DM_WRITE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && byte_en != 4'b0000)
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  assign byte_shift = word >> {addr[1:0], 3'b000};
  assign half_shift = word >> {addr[1], 4'b0000};

  always_comb begin
    rdata = word;
    case (load_op)
      LD_LH:   rdata = {{16{half_shift[15]}}, half_shift[15:0]};
      LD_LHU:  rdata = {16'h0, half_shift[15:0]};
      LD_LB:   rdata = {{24{byte_shift[7]}}, byte_shift[7:0]};
      LD_LBU:  rdata = {24'h0, byte_shift[7:0]};
      default: rdata = word;
    endcase
  end

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: directed steps push expected rdata/byte_en,
// a negedge monitor pops and compares.
module tb_dm_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  store_op;
  logic [2:0]  load_op;
  logic [31:0] rdata;
  logic [3:0]  byte_en;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];
  logic tx_valid = 1'b0;
  logic done     = 1'b0;
  int   n_pass   = 0;
  int   n_total  = 0;

  dm_stage dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .addr     (addr),
    .wdata    (wdata),
    .store_op (store_op),
    .load_op  (load_op),
    .rdata    (rdata),
    .byte_en  (byte_en)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] NONE = 2'b00, SW = 2'b01, SH = 2'b10, SB = 2'b11;
  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;

  task automatic step(input string name, input logic rst, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] so, input logic [2:0] lo,
                      input logic chk, input logic [31:0] exp_rd, input logic [3:0] exp_be);
    exp_t e;
    reset    = rst;
    addr     = a;
    wdata    = wd;
    store_op = so;
    load_op  = lo;
    if (chk) begin
      e.name = name;
      e.rd   = exp_rd;
      e.be   = exp_be;
      sb_q.push_back(e);
    end
    tx_valid = chk;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares on the falling edge, away from the commit edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
      if (tx_valid) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_empty: monitor found no expected entry");
        end else begin
          e = sb_q.pop_front();
          n_total++;
          if (rdata === e.rd) n_pass++;
          else $display("FAIL %s.rdata: got %h, required %h", e.name, rdata, e.rd);
          n_total++;
          if (byte_en === e.be) n_pass++;
          else $display("FAIL %s.byte_en: got %b, required %b", e.name, byte_en, e.be);
          $display("txn %s addr=%h st=%b ld=%b rdata=%h byte_en=%b", e.name, addr, store_op, load_op, rdata, byte_en);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pc = 32'h0; addr = 32'h0; wdata = 32'h0; store_op = NONE; load_op = LW;
    @(posedge clk); #1;
    step("reset",        1'b1, 32'h10, 32'h0, NONE, LW, 1'b0, 32'h0, 4'b0000);
    step("reset_lw",     1'b0, 32'h10, 32'h0, NONE, LW, 1'b1, 32'h0, 4'b0000);
    step("sw_same_cyc",  1'b0, 32'h10, 32'h87654321, SW, LW, 1'b1, 32'h0, 4'b1111);
    step("sw_lw",        1'b0, 32'h10, 32'h0, NONE, LW, 1'b1, 32'h87654321, 4'b0000);
    step("sb_same_cyc",  1'b0, 32'h13, 32'h000000AB, SB, LW, 1'b1, 32'h87654321, 4'b1000);
    step("sb_lw",        1'b0, 32'h10, 32'h0, NONE, LW,  1'b1, 32'hAB654321, 4'b0000);
    step("sb_lb",        1'b0, 32'h13, 32'h0, NONE, LB,  1'b1, 32'hFFFFFFAB, 4'b0000);
    step("sb_lbu",       1'b0, 32'h13, 32'h0, NONE, LBU, 1'b1, 32'h000000AB, 4'b0000);
    step("sh_same_cyc",  1'b0, 32'h12, 32'h00009ABC, SH, LW, 1'b1, 32'hAB654321, 4'b1100);
    step("sh_lw",        1'b0, 32'h10, 32'h0, NONE, LW,  1'b1, 32'h9ABC4321, 4'b0000);
    step("sh_lh",        1'b0, 32'h12, 32'h0, NONE, LH,  1'b1, 32'hFFFF9ABC, 4'b0000);
    step("sh_lhu",       1'b0, 32'h10, 32'h0, NONE, LHU, 1'b1, 32'h00004321, 4'b0000);
    step("lb_lane0",     1'b0, 32'h10, 32'h0, NONE, LB,  1'b1, 32'h00000021, 4'b0000);
    step("lh_lo",        1'b0, 32'h10, 32'h0, NONE, LH,  1'b1, 32'h00004321, 4'b0000);
    step("oor_sw",       1'b0, 32'h3000, 32'hFFFFFFFF, SW, LW, 1'b1, 32'h0, 4'b0000);
    step("oor_lw",       1'b0, 32'h3000, 32'h0, NONE, LW, 1'b1, 32'h0, 4'b0000);
    step("oor_lb",       1'b0, 32'h3003, 32'h0, NONE, LB, 1'b1, 32'h0, 4'b0000);
    step("alias_sw",     1'b0, 32'h00010010, 32'hFFFFFFFF, SW, LW, 1'b1, 32'h0, 4'b0000);
    step("alias_chk",    1'b0, 32'h10, 32'h0, NONE, LW, 1'b1, 32'h9ABC4321, 4'b0000);
    step("last_sw",      1'b0, 32'h2FFC, 32'hCAFEBABE, SW, LW, 1'b1, 32'h0, 4'b1111);
    step("last_lw",      1'b0, 32'h2FFC, 32'h0, NONE, LW, 1'b1, 32'hCAFEBABE, 4'b0000);
    step("rst_sw",       1'b1, 32'h4, 32'h12345678, SW, LW, 1'b1, 32'h0, 4'b1111);
    step("rst_lw4",      1'b0, 32'h4, 32'h0, NONE, LW, 1'b1, 32'h0, 4'b0000);
    step("rst_lw10",     1'b0, 32'h10, 32'h0, NONE, LW, 1'b1, 32'h0, 4'b0000);
    pc = 32'h00003008;
    step("post_rst_sw",  1'b0, 32'h4, 32'h12345678, SW, LW, 1'b1, 32'h0, 4'b1111);
    pc = 32'h0;
    step("post_rst_lw",  1'b0, 32'h4, 32'h0, NONE, LW,   1'b1, 32'h12345678, 4'b0000);
    step("ld_op_101",    1'b0, 32'h4, 32'h0, NONE, 3'b101, 1'b1, 32'h12345678, 4'b0000);
    step("lh_hi",        1'b0, 32'h6, 32'h0, NONE, LH,   1'b1, 32'h00001234, 4'b0000);
    step("sb_lane1",     1'b0, 32'h5, 32'h00000080, SB, LB, 1'b1, 32'h00000056, 4'b0010);
    step("sb_lane1_lb",  1'b0, 32'h5, 32'h0, NONE, LB,   1'b1, 32'hFFFFFF80, 4'b0000);
    step("sb_lane1_lw",  1'b0, 32'h4, 32'h0, NONE, LW,   1'b1, 32'h12348078, 4'b0000);
    step("b2b_sb0",      1'b0, 32'h20, 32'h00000011, SB, LW, 1'b1, 32'h0, 4'b0001);
    step("b2b_sb1",      1'b0, 32'h21, 32'h00000022, SB, LW, 1'b1, 32'h00000011, 4'b0010);
    step("b2b_sh_lo",    1'b0, 32'h20, 32'hFFFF0000, SH, LW, 1'b1, 32'h00002211, 4'b0011);
    step("b2b_lw",       1'b0, 32'h20, 32'h0, NONE, LW, 1'b1, 32'h00000000, 4'b0000);
    step("sw_ignore_lsb",1'b0, 32'h23, 32'hA5A5A5A5, SW, LW, 1'b1, 32'h0, 4'b1111);
    step("sw_ignore_chk",1'b0, 32'h20, 32'h0, NONE, LW, 1'b1, 32'hA5A5A5A5, 4'b0000);
    tx_valid = 1'b0;
    store_op = NONE;
    @(posedge clk); #1;
    done = 1'b1;
  end

endmodule
